// File: rtl/mem_io_responder_pkg.sv
// Shared address map and status-register layout for the RAM/IO responder.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_BASE        = 32'h0003_0000;
    localparam logic [31:0] IO_UART_ADDR   = 32'h0003_0000;
    localparam logic [31:0] IO_STATUS_ADDR = 32'h0003_0004;

    localparam int unsigned TX_FULL_BIT  = 1;
    localparam int unsigned RX_VALID_BIT = 0;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

    function automatic logic is_status_addr(input logic [31:0] addr);
        return addr[2] == IO_STATUS_ADDR[2];
    endfunction

    function automatic logic is_uart_addr(input logic [31:0] addr);
        return addr[2] == IO_UART_ADDR[2];
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// First-word fall-through byte FIFO; the caller only pushes when not full or popping.
module byte_fifo #(
    parameter int unsigned DEPTH_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   empty,
    output logic                   full,
    output logic [DEPTH_WIDTH:0]   count
);

    localparam logic [DEPTH_WIDTH:0] DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};

    logic [7:0]             mem [2**DEPTH_WIDTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_WIDTH:0]   count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (DEPTH_WIDTH + 1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_WIDTH + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH);
    assign count = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the controller's byte bus: on-chip RAM plus a UART/status IO window,
// with 1-cycle read latency and TX FIFO back-pressure.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH_WIDTH = 3,
    parameter int unsigned IO_FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [31:0] mem_ram_addr,
    input  logic [7:0]  mem_ram_data,
    input  logic        mem_ram_wr,
    output logic [7:0]  ram_data,
    output logic        io_buffer_full,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ack,
    output logic        program_end,
    output logic        tx_overflow
);

    localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_WIDTH;

    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] idx;
    logic                      is_io, is_status, is_uart;
    logic                      wr_ram, wr_uart, wr_end, rd_uart;
    logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [TX_DEPTH_WIDTH:0]   fifo_count;
    logic [7:0]                ram_q, rx_q, status;
    logic                      io_q, reg_q, rx_valid_q, ack_q, end_q, overflow_q;

    always_comb begin
        idx       = mem_ram_addr[RAM_ADDR_WIDTH-1:0];
        is_io     = is_io_addr(mem_ram_addr);
        is_status = is_status_addr(mem_ram_addr);
        is_uart   = is_uart_addr(mem_ram_addr);
        wr_ram    = mem_ram_wr && !is_io;
        wr_uart   = mem_ram_wr && is_io && is_uart;
        wr_end    = mem_ram_wr && is_io && is_status;
        rd_uart   = !mem_ram_wr && is_io && is_uart;
        fifo_pop  = rdy && !fifo_empty && uart_tx_ready;
        // A pop on the same edge frees the slot, so a push while full still lands.
        fifo_push = rdy && wr_uart && (!fifo_full || fifo_pop);
    end

    byte_fifo #(
        .DEPTH_WIDTH (TX_DEPTH_WIDTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_ram_data),
        .dout  (uart_tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rdy && wr_ram) begin
            ram[idx] <= mem_ram_data;
        end
    end

    // Read-first: the registered read sees the byte before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q <= '0;
        end else if (rdy) begin
            ram_q <= ram[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_q       <= 1'b0;
            reg_q      <= 1'b0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            end_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else if (rdy) begin
            io_q       <= is_io;
            reg_q      <= is_status;
            rx_valid_q <= uart_rx_valid;
            ack_q      <= rd_uart && uart_rx_valid;
            end_q      <= wr_end;
            if (rd_uart) begin
                rx_q <= uart_rx_valid ? uart_rx_data : 8'h00;
            end
            if (wr_uart && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        status               = '0;
        status[TX_FULL_BIT]  = fifo_full;
        status[RX_VALID_BIT] = rx_valid_q;
        ram_data             = ram_q;
        if (io_q) begin
            ram_data = reg_q ? status : rx_q;
        end
    end

    assign io_buffer_full = (TX_DEPTH - 32'(fifo_count)) < IO_FULL_MARGIN;
    assign uart_tx_valid  = !fifo_empty;
    assign uart_rx_ack    = ack_q;
    assign program_end    = end_q;
    assign tx_overflow    = overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized bench for mem_io_responder against a queue/array reference model.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] mem_ram_addr = '0;
    logic [7:0]  mem_ram_data = '0;
    logic        mem_ram_wr = 1'b0;
    logic [7:0]  ram_data;
    logic        io_buffer_full;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ack;
    logic        program_end;
    logic        tx_overflow;

    mem_io_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .mem_ram_addr   (mem_ram_addr),
        .mem_ram_data   (mem_ram_data),
        .mem_ram_wr     (mem_ram_wr),
        .ram_data       (ram_data),
        .io_buffer_full (io_buffer_full),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_valid  (uart_tx_valid),
        .uart_tx_ready  (uart_tx_ready),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_valid  (uart_rx_valid),
        .uart_rx_ack    (uart_rx_ack),
        .program_end    (program_end),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] ram_m [int];
    logic [7:0] q_m [$];
    logic [7:0] exp_rd;
    logic       rd_known;
    logic [7:0] rx_m;
    logic       ack_m, pend_m, ovf_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_addr(input int i);
        logic [31:0] r = $urandom();
        return {r[31:17], 12'b0, i[4:0]};
    endfunction

    function automatic logic [31:0] io_addr(input logic sel);
        logic [31:0] r = $urandom();
        return {r[31:18], 2'b11, r[15:3], sel, r[1:0]};
    endfunction

    task automatic model_reset();
        q_m.delete();
        exp_rd   = 8'h00;
        rd_known = 1'b1;
        rx_m     = 8'h00;
        ack_m    = 1'b0;
        pend_m   = 1'b0;
        ovf_m    = 1'b0;
    endtask

    task automatic check_outputs();
        if (rd_known) check("ram_data", ram_data, exp_rd);
        check("io_buffer_full", io_buffer_full, (8 - q_m.size()) < 2);
        check("tx_valid", uart_tx_valid, q_m.size() > 0);
        if (q_m.size() > 0) check("tx_data", uart_tx_data, q_m[0]);
        check("rx_ack", uart_rx_ack, ack_m);
        check("program_end", program_end, pend_m);
        check("tx_overflow", tx_overflow, ovf_m);
    endtask

    // Drive one bus cycle, advance the model by one enabled edge, then check.
    task automatic cycle(input logic [31:0] a, input logic [7:0] d, input logic w,
                         input logic txr, input logic rxv, input logic [7:0] rxd,
                         input logic en);
        int  idx;
        logic io, st, pop, was_full;
        mem_ram_addr  = a;
        mem_ram_data  = d;
        mem_ram_wr    = w;
        uart_tx_ready = txr;
        uart_rx_valid = rxv;
        uart_rx_data  = rxd;
        rdy           = en;
        if (en) begin
            idx      = int'(a[16:0]);
            io       = (a[17:16] == 2'b11);
            st       = a[2];
            pop      = (q_m.size() > 0) && txr;
            was_full = (q_m.size() == 8);
            if (!io) begin
                rd_known = ram_m.exists(idx);
                if (rd_known) exp_rd = ram_m[idx];
                if (w) ram_m[idx] = d;
            end
            ack_m  = !w && io && !st && rxv;
            pend_m = w && io && st;
            if (!w && io && !st) rx_m = rxv ? rxd : 8'h00;
            if (pop) void'(q_m.pop_front());
            if (w && io && !st) begin
                if (!was_full || pop) q_m.push_back(d);
                else ovf_m = 1'b1;
            end
            if (io) begin
                rd_known = 1'b1;
                exp_rd   = st ? {6'b0, q_m.size() == 8, rxv} : rx_m;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        cycle(ram_addr(5'h10), 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // Async reset asserted away from the clock edge; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ram_data", ram_data, 8'h00);
        check("rst_io_full", io_buffer_full, 1'b0);
        check("rst_tx_valid", uart_tx_valid, 1'b0);
        check("rst_rx_ack", uart_rx_ack, 1'b0);
        check("rst_prog_end", program_end, 1'b0);
        check("rst_overflow", tx_overflow, 1'b0);
        model_reset();
        rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Fill the RAM address pool so every later read has a known value.
        for (int i = 0; i < 32; i++) begin
            cycle(ram_addr(i), 8'($urandom()), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end

        cycle(ram_addr(5'h10), 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cycle(ram_addr(5'h10), 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rd_a5", ram_data, 8'hA5);

        for (int i = 1; i <= 9; i++) begin
            cycle(io_addr(1'b0), 8'(i), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            if (i == 6) check("nearfull_after_6", io_buffer_full, 1'b0);
            if (i == 7) check("nearfull_after_7", io_buffer_full, 1'b1);
        end
        check("overflow_after_9", tx_overflow, 1'b1);

        cycle(io_addr(1'b1), 8'h00, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
        check("status_full_rxv", ram_data, 8'h03);

        for (int i = 1; i <= 8; i++) begin
            check("drain_head", uart_tx_data, 8'(i));
            cycle(ram_addr(5'h10), 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
            if (i == 2) check("nearfull_drop", io_buffer_full, 1'b0);
        end
        check("drained", uart_tx_valid, 1'b0);

        cycle(io_addr(1'b0), 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1);
        check("rx_byte", ram_data, 8'h3C);
        check("rx_ack_pulse", uart_rx_ack, 1'b1);
        idle();
        check("rx_ack_single", uart_rx_ack, 1'b0);
        cycle(io_addr(1'b0), 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
        check("rx_empty_byte", ram_data, 8'h00);
        check("rx_no_ack", uart_rx_ack, 1'b0);

        cycle(io_addr(1'b1), 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("prog_end_high", program_end, 1'b1);
        idle();
        check("prog_end_low", program_end, 1'b0);

        for (int i = 0; i < 3; i++) begin
            cycle(io_addr(1'b0), 8'h40 + 8'(i), 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        cycle(ram_addr(5'h10), 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        do_reset();
        idle();
        check("post_rst_empty", uart_tx_valid, 1'b0);
        check("post_rst_ram", ram_data, 8'hA5);

        cycle(ram_addr(5'h10), 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(io_addr(1'b0), 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("frozen_fifo", uart_tx_valid, 1'b0);
        idle();
        check("frozen_ram", ram_data, 8'hA5);

        for (int i = 0; i < 3000; i++) begin
            int          pick;
            logic [31:0] a;
            if (i == 1500) do_reset();
            pick = $urandom_range(0, 99);
            if (pick < 60)      a = ram_addr($urandom_range(0, 31));
            else if (pick < 82) a = io_addr(1'b0);
            else                a = io_addr(1'b1);
            cycle(a, 8'($urandom()), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  8'($urandom()), $urandom_range(0, 9) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the byte-wide RAM bus driven by memory_controller. Inputs from the controller are mem_ram_addr, mem_ram_data and mem_ram_wr; outputs back to it are ram_data and io_buffer_full.
- Decodes each address into either on-chip byte RAM or the memory-mapped IO window at 0x30000/0x30004.
- Buffers outgoing UART bytes in a TX FIFO and returns read data with fixed 1-cycle latency.
- Generates io_buffer_full back-pressure toward the controller.

Parameters:
- RAM_ADDR_WIDTH, 17, byte RAM index width (2^17 bytes).
- TX_DEPTH_WIDTH, 3, log2 of TX FIFO depth (8 entries).
- IO_FULL_MARGIN, 2, io_buffer_full asserts when free TX entries < this value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state frozen.
- mem_ram_addr  in  32  byte address from controller.
- mem_ram_data  in  8  write byte from controller.
- mem_ram_wr  in  1  1 = write, 0 = read.
- ram_data  out  8  read byte; valid the cycle after its address is presented.
- io_buffer_full  out  1  TX FIFO near-full, to controller.
- uart_tx_data  out  8  FIFO head byte.
- uart_tx_valid  out  1  FIFO non-empty.
- uart_tx_ready  in  1  UART accepts head this cycle.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  rx byte available.
- uart_rx_ack  out  1  one-cycle pulse: rx byte consumed.
- program_end  out  1  one-cycle pulse on write to 0x30004.
- tx_overflow  out  1  sticky: a push was attempted while FIFO full.

Behaviour:
- Decode:
  - io = (addr[17:16] == 2'b11).
  - RAM index = addr[RAM_ADDR_WIDTH-1:0].
  - IO register = addr[2]: 0 → UART at 0x30000, 1 → status/end at 0x30004.
- Gating: all actions below occur only on posedge clk with rdy = 1. With rdy = 0: no push, no pop, no ack, no RAM write; ram_data holds its value.
- RAM write: wr && !io → ram[idx] <= mem_ram_data.
- RAM read: synchronous. Registered ram_q = ram[idx] every enabled cycle. Read-first: a same-cycle write returns the old byte.
- Output select: io_q and reg_q are registered with the address. The next-cycle ram_data mux is:
  - io_q = 0 → ram_q.
  - io_q = 1 and reg_q = 0 → rx_q.
  - io_q = 1 and reg_q = 1 → {6'b0, fifo_full, uart_rx_valid_q}.
- IO write 0x30000:
  - FIFO not full → push mem_ram_data.
  - FIFO full → byte dropped; tx_overflow <= 1 (cleared only by reset).
- IO write 0x30004: program_end = 1 for exactly the next cycle; no FIFO effect.
- IO read 0x30000:
  - uart_rx_valid = 1 → rx_q <= uart_rx_data; uart_rx_ack pulses next cycle.
  - uart_rx_valid = 0 → rx_q <= 0x00; no ack.
  - One pop per qualifying cycle. The controller presents an IO address for a single cycle.
- TX FIFO (first-word fall-through):
  - uart_tx_valid = !empty; uart_tx_data = mem[rd_ptr].
  - Pop when uart_tx_valid && uart_tx_ready.
  - Pointers wrap modulo 2^TX_DEPTH_WIDTH.
  - count has TX_DEPTH_WIDTH+1 bits.
  - Simultaneous push and pop (including when full) → count unchanged. Pop frees a slot in the same edge, so a push while full with a pop is accepted.
- io_buffer_full = (2^TX_DEPTH_WIDTH − count) < IO_FULL_MARGIN. Combinational from the registered count.
- Reset (async assert, sync-safe release):
  - ram_data = 0, io_buffer_full = 0, uart_tx_valid = 0, uart_rx_ack = 0, program_end = 0, tx_overflow = 0.
  - FIFO emptied; ptrs = 0.
  - RAM contents are not reset.
  - Reset mid-transfer discards queued TX bytes.

Decomposition:
- global_params.v gains:
  - `IO_BASE 0x30000
  - `IO_UART_ADDR 0x30000
  - `IO_STATUS_ADDR 0x30004
  - status bit positions: TX_FULL_BIT = 1, RX_VALID_BIT = 0.
- One sub-module: byte_fifo (parameter DEPTH_WIDTH). Interface: push/pop/din/dout/empty/full/count.
- RAM array, decode and read mux stay in mem_io_responder.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 → ram_data = 0xA5 exactly one cycle after the read address.
- Write 9 bytes 0x01..0x09 to 0x30000 with uart_tx_ready = 0 → 8 entries queued; io_buffer_full rises after the 7th push; 9th byte dropped; tx_overflow = 1.
- Then raise uart_tx_ready → uart_tx_data sequence 0x01..0x08; uart_tx_valid = 0 after 8 cycles; io_buffer_full falls once count ≤ 6.
- Read 0x30000 with uart_rx_valid = 1, uart_rx_data = 0x3C → ram_data = 0x3C next cycle; uart_rx_ack single pulse. Repeat with rx_valid = 0 → ram_data = 0x00, no ack.
- Write to 0x30004 → program_end high exactly one cycle. Read 0x30004 with FIFO full, rx_valid = 1 → ram_data = 0x03.
- Push 3 bytes, assert rst_n = 0 mid-drain → outputs reset immediately (async); after release, FIFO empty and a previously written RAM byte still reads back intact. Hold rdy = 0 during a write → no RAM or FIFO change.
